// File: rtl/bs_cmd_queue_if.sv
// Handshake/bus bundle for bs_cmd_queue: command input, shifter feed/return, result output.
// The slave modport is the queue's view; the master modport is the view of whatever drives it.
interface bs_cmd_queue_if #(
  parameter int DATA_W  = 8,
  parameter int SHAMT_W = 3
);
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic [SHAMT_W-1:0] in_range;
  logic [DATA_W-1:0]  bs_a;
  logic [SHAMT_W-1:0] bs_range;
  logic [DATA_W-1:0]  bs_out;
  logic               res_valid;
  logic               res_ready;
  logic [DATA_W-1:0]  res_data;
  logic [SHAMT_W-1:0] res_range;

  modport slave (
    input  in_valid, in_data, in_range, bs_out, res_ready,
    output in_ready, bs_a, bs_range, res_valid, res_data, res_range
  );

  modport master (
    output in_valid, in_data, in_range, bs_out, res_ready,
    input  in_ready, bs_a, bs_range, res_valid, res_data, res_range
  );
endinterface

// File: rtl/bs_cmd_queue.sv
// Show-ahead command FIFO feeding an external combinational barrel shifter, with a registered result stage.
// Optional macro BS_CMD_QUEUE_CNT_EN adds a saturating 16-bit done_cnt of completed commands.
module bs_cmd_queue #(
  parameter int DATA_W  = 8,
  parameter int SHAMT_W = 3,
  parameter int DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  bs_cmd_queue_if.slave          bus,
  output logic [$clog2(DEPTH):0] level
`ifdef BS_CMD_QUEUE_CNT_EN
  ,
  output logic [15:0]            done_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0]  data_mem_q  [DEPTH];
  logic [DATA_W-1:0]  data_mem_d  [DEPTH];
  logic [SHAMT_W-1:0] range_mem_q [DEPTH];
  logic [SHAMT_W-1:0] range_mem_d [DEPTH];

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               res_valid_q, res_valid_d;
  logic [DATA_W-1:0]  res_data_q, res_data_d;
  logic [SHAMT_W-1:0] res_range_q, res_range_d;

  logic               not_empty;
  logic               in_ready;
  logic               push;
  logic               pop;
  logic [DATA_W-1:0]  head_data;
  logic [SHAMT_W-1:0] head_range;

  // Head and handshake decode, all from registered state
  always_comb begin
    not_empty  = (count_q != '0);
    in_ready   = (count_q < CNT_W'(DEPTH));
    push       = bus.in_valid && in_ready;
    pop        = not_empty && (!res_valid_q || bus.res_ready);
    head_data  = not_empty ? data_mem_q[rd_ptr_q]  : '0;
    head_range = not_empty ? range_mem_q[rd_ptr_q] : '0;
  end

  // Next state: FIFO storage, pointers, occupancy and result register
  always_comb begin
    data_mem_d  = data_mem_q;
    range_mem_d = range_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_range_d = res_range_q;

    if (push) begin
      data_mem_d[wr_ptr_q]  = bus.in_data;
      range_mem_d[wr_ptr_q] = bus.in_range;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      res_data_d  = bus.bs_out;
      res_range_d = head_range;
      res_valid_d = 1'b1;
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
    end else if (bus.res_ready) begin
      res_valid_d = 1'b0;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_range_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_range_q <= res_range_d;
    end
  end

  // Entry storage carries no reset; stale entries are never visible past count_q
  always_ff @(posedge clk) begin
    data_mem_q  <= data_mem_d;
    range_mem_q <= range_mem_d;
  end

`ifdef BS_CMD_QUEUE_CNT_EN
  logic [15:0] done_cnt_q, done_cnt_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    done_cnt_d = done_cnt_q;
    if (pop) done_cnt_d = sat_inc(done_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) done_cnt_q <= '0;
    else     done_cnt_q <= done_cnt_d;
  end

  assign done_cnt = done_cnt_q;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.bs_a      = head_data;
  assign bus.bs_range  = head_range;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_range = res_range_q;
  assign level         = count_q;

endmodule

// File: tb/tb_bs_cmd_queue.sv
// Directed bench for bs_cmd_queue; the external shifter is modelled as an 8-bit left rotate.
module tb_bs_cmd_queue;

  localparam int DATA_W  = 8;
  localparam int SHAMT_W = 3;
  localparam int DEPTH   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [$clog2(DEPTH):0] level;
`ifdef BS_CMD_QUEUE_CNT_EN
  logic [15:0] done_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bs_cmd_queue_if #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) bus ();

  function automatic logic [7:0] rotl(input logic [7:0] a, input logic [2:0] s);
    logic [15:0] w;
    w = {a, a} << s;
    return w[15:8];
  endfunction

  assign bus.bs_out = rotl(bus.bs_a, bus.bs_range);

  bs_cmd_queue #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .level    (level)
`ifdef BS_CMD_QUEUE_CNT_EN
    ,
    .done_cnt (done_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] r);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_range = r;
  endtask

  task automatic check_res(input string tag, input logic [7:0] d, input logic [2:0] r);
    check({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
    check({tag, "_data"},  32'(bus.res_data),  32'(d));
    check({tag, "_range"}, 32'(bus.res_range), 32'(r));
  endtask

  initial begin
    drive(1'b0, 8'h00, 3'd0);
    bus.res_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_level",     32'(level),         32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_data",  32'(bus.res_data),  32'd0);
    check("rst_res_range", 32'(bus.res_range), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_bs_a",      32'(bus.bs_a),      32'd0);
    check("rst_bs_range",  32'(bus.bs_range),  32'd0);

    // Single command
    bus.res_ready = 1'b1;
    drive(1'b1, 8'h37, 3'd5);
    tick();
    drive(1'b0, 8'h00, 3'd0);
    check("one_head_a",   32'(bus.bs_a),      32'h37);
    check("one_level1",   32'(level),         32'd1);
    check("one_not_yet",  32'(bus.res_valid), 32'd0);
    tick();
    check_res("one_res", 8'hE6, 3'd5);
    check("one_level0", 32'(level), 32'd0);
    tick();
    check("one_drop_valid", 32'(bus.res_valid), 32'd0);
    check("one_drop_level", 32'(level),         32'd0);

    // Back-to-back
    drive(1'b1, 8'h37, 3'd0);
    tick();
    drive(1'b1, 8'h37, 3'd7);
    tick();
    check_res("b2b0", 8'h37, 3'd0);
    drive(1'b1, 8'h37, 3'd5);
    tick();
    check_res("b2b1", 8'h9B, 3'd7);
    drive(1'b0, 8'h00, 3'd0);
    tick();
    check_res("b2b2", 8'hE6, 3'd5);
    tick();
    check("b2b_end_valid", 32'(bus.res_valid), 32'd0);

    // Backpressure and full
    bus.res_ready = 1'b0;
    drive(1'b1, 8'h37, 3'd0); tick();
    drive(1'b1, 8'h37, 3'd7); tick();
    check_res("bp_first", 8'h37, 3'd0);
    drive(1'b1, 8'h37, 3'd5); tick();
    drive(1'b1, 8'h01, 3'd1); tick();
    drive(1'b1, 8'h80, 3'd1); tick();
    check("bp_full_level", 32'(level),        32'd4);
    check("bp_full_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 8'h0F, 3'd4); tick();
    check("bp_no_overwrite", 32'(level), 32'd4);
    check_res("bp_hold", 8'h37, 3'd0);
    tick();
    check_res("bp_hold2", 8'h37, 3'd0);
    bus.res_ready = 1'b1;
    tick();
    check_res("bp_r1", 8'h9B, 3'd7);
    check("bp_r1_level", 32'(level),        32'd3);
    check("bp_r1_ready", 32'(bus.in_ready), 32'd1);
    tick();
    drive(1'b0, 8'h00, 3'd0);
    check_res("bp_r2", 8'hE6, 3'd5);
    check("bp_r2_level", 32'(level), 32'd3);
    tick();
    check_res("bp_r3", 8'h02, 3'd1);
    tick();
    check_res("bp_r4", 8'h01, 3'd1);
    tick();
    check_res("bp_r5", 8'hF0, 3'd4);
    check("bp_r5_level", 32'(level), 32'd0);
    tick();
    check("bp_end_valid", 32'(bus.res_valid), 32'd0);

    // Simultaneous push/pop at level 2
    bus.res_ready = 1'b0;
    drive(1'b1, 8'h11, 3'd1); tick();
    drive(1'b1, 8'h22, 3'd2); tick();
    drive(1'b1, 8'h33, 3'd3); tick();
    check("pp_level2", 32'(level), 32'd2);
    bus.res_ready = 1'b1;
    drive(1'b1, 8'h44, 3'd4); tick();
    check_res("pp_r1", 8'h88, 3'd2);
    check("pp_keep1", 32'(level), 32'd2);
    drive(1'b1, 8'h55, 3'd5); tick();
    check_res("pp_r2", 8'h99, 3'd3);
    check("pp_keep2", 32'(level), 32'd2);
    drive(1'b0, 8'h00, 3'd0); tick();
    check_res("pp_r3", 8'h44, 3'd4);
    tick();
    check_res("pp_r4", 8'hAA, 3'd5);
    check("pp_level0", 32'(level), 32'd0);
    tick();

    // Reset mid-operation
    bus.res_ready = 1'b0;
    drive(1'b1, 8'h12, 3'd1); tick();
    drive(1'b1, 8'h34, 3'd2); tick();
    drive(1'b1, 8'h56, 3'd3); tick();
    drive(1'b1, 8'h78, 3'd4); tick();
    drive(1'b0, 8'h00, 3'd0);
    check("mr_level3", 32'(level),         32'd3);
    check("mr_valid",  32'(bus.res_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_level",     32'(level),         32'd0);
    check("mr_res_valid", 32'(bus.res_valid), 32'd0);
    check("mr_res_data",  32'(bus.res_data),  32'd0);
    check("mr_in_ready",  32'(bus.in_ready),  32'd1);
    check("mr_bs_a",      32'(bus.bs_a),      32'd0);
    bus.res_ready = 1'b1;
    drive(1'b1, 8'h37, 3'd7); tick();
    drive(1'b0, 8'h00, 3'd0); tick();
    check_res("mr_fresh", 8'h9B, 3'd7);
    tick();

`ifdef BS_CMD_QUEUE_CNT_EN
    drive(1'b1, 8'h01, 3'd1); tick();
    drive(1'b1, 8'h02, 3'd1); tick();
    drive(1'b0, 8'h00, 3'd0); tick();
    check("cnt_three", 32'(done_cnt), 32'd3);
    tick();
    force dut.done_cnt_q = 16'hFFFF;
    #1;
    release dut.done_cnt_q;
    drive(1'b1, 8'h03, 3'd1); tick();
    drive(1'b0, 8'h00, 3'd0); tick();
    check("cnt_sat", 32'(done_cnt), 32'h0000FFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
